// File: rtl/act_bram_tile_loader.sv
// Streams a row-major tile from a 32-bit BRAM into ARRAY_N row RAMs,
// absorbing the one-cycle BRAM read latency with a single write-side register stage.
module act_bram_tile_loader #(
    parameter int ARRAY_N    = 8,
    parameter int RAM_SIZE   = 1024,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [31:0]                bram_base_addr,
    input  logic [$clog2(ARRAY_N):0]   num_rows,
    input  logic [ADDR_WIDTH:0]        row_len,
    input  logic [ADDR_WIDTH-1:0]      ram_base_addr,
    input  logic                       hold,
    output logic [31:0]                bram_addr,
    output logic                       bram_en,
    input  logic [DATA_WIDTH-1:0]      bram_rdata,
    output logic [ARRAY_N-1:0]         ram_w_en,
    output logic [ADDR_WIDTH-1:0]      ram_w_addr,
    output logic [DATA_WIDTH-1:0]      ram_w_data,
    output logic                       busy,
    output logic                       done,
    output logic                       cmd_err
);

    localparam int NRW = $clog2(ARRAY_N) + 1;
    localparam int RW  = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1;
    localparam int LW  = ADDR_WIDTH + 1;

    localparam logic [NRW-1:0] MAX_ROWS = NRW'(ARRAY_N);
    localparam logic [LW-1:0]  MAX_LEN  = LW'(RAM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [31:0]           r_base;
    logic [NRW-1:0]        r_nrows;
    logic [LW-1:0]         r_rowlen;
    logic [ADDR_WIDTH-1:0] r_rbase;

    logic [RW-1:0]         r_row;
    logic [LW-1:0]         r_col;
    logic [29:0]           r_off;

    logic [31:0]           r_last_addr;
    logic [ARRAY_N-1:0]    r_wen;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic                  r_cmd_err;

    logic                  w_illegal;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_last_col;
    logic                  w_last_row;
    logic [31:0]           w_cur_addr;
    logic [ARRAY_N-1:0]    w_onehot;

    assign w_illegal = (num_rows == '0) || (num_rows > MAX_ROWS) ||
                       (row_len == '0) || (row_len > MAX_LEN) ||
                       (bram_base_addr[1:0] != 2'b00);
    assign w_accept   = (r_state == S_IDLE) && start && !w_illegal;
    assign w_issue    = (r_state == S_ISSUE) && !hold;
    assign w_last_col = (r_col == r_rowlen - 1'b1);
    assign w_last_row = (NRW'(r_row) == r_nrows - 1'b1);
    // Running word offset r*row_len+k, so no multiplier is needed.
    assign w_cur_addr = r_base + {r_off, 2'b00};
    assign w_onehot   = ARRAY_N'(1) << r_row;

    assign ram_w_en   = r_wen;
    assign ram_w_addr = r_waddr;
    assign ram_w_data = bram_rdata;
    assign cmd_err    = r_cmd_err;

    always_comb begin
        w_next    = r_state;
        bram_en   = 1'b0;
        bram_addr = r_last_addr;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (w_issue) begin
                    bram_en   = 1'b1;
                    bram_addr = w_cur_addr;
                    if (w_last_col && w_last_row) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy   = 1'b1;
                w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_nrows     <= '0;
            r_rowlen    <= '0;
            r_rbase     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_off       <= '0;
            r_last_addr <= '0;
            r_wen       <= '0;
            r_waddr     <= '0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cmd_err <= (r_state == S_IDLE) && start && w_illegal;
            if (w_accept) begin
                r_base   <= bram_base_addr;
                r_nrows  <= num_rows;
                r_rowlen <= row_len;
                r_rbase  <= ram_base_addr;
                r_row    <= '0;
                r_col    <= '0;
                r_off    <= '0;
            end
            if (w_issue) begin
                r_last_addr <= w_cur_addr;
                r_off       <= r_off + 30'd1;
                r_waddr     <= r_rbase + r_col[ADDR_WIDTH-1:0];
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_wen <= w_issue ? w_onehot : '0;
        end
    end

endmodule

// File: doc/act_bram_tile_loader.md
Name: act_bram_tile_loader

Overview:
- Upstream feeder for the systolic activation/weight buffers.
- On a start command it streams a row-major tile out of a 32-bit BRAM, one word per cycle, and absorbs the 1-cycle BRAM read latency internally.
- Each returned word is steered to one of ARRAY_N per-row buffer RAMs as a one-hot write enable, a RAM-local address and the data.
- It replaces the external delay registers around the BRAM-to-buffer path and adds command, stall and completion handshakes.

Parameters:
- ARRAY_N, 8, number of destination row RAMs (one-hot write-enable width).
- RAM_SIZE, 1024, depth of each destination RAM in words.
- ADDR_WIDTH, $clog2(RAM_SIZE), RAM-local address width.
- DATA_WIDTH, 32, BRAM/RAM word width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- bram_base_addr  input  32  byte address of tile word (0,0); must be 4-aligned.
- num_rows  input  $clog2(ARRAY_N)+1  rows to load (1..ARRAY_N).
- row_len  input  ADDR_WIDTH+1  words per row (1..RAM_SIZE).
- ram_base_addr  input  ADDR_WIDTH  first RAM-local address written in every row RAM.
- hold  input  1  stall request; blocks new BRAM reads.
- bram_addr  output  32  BRAM byte address.
- bram_en  output  1  BRAM read enable.
- bram_rdata  input  DATA_WIDTH  BRAM read data; valid the cycle after bram_en.
- ram_w_en  output  ARRAY_N  one-hot row-RAM write enable.
- ram_w_addr  output  ADDR_WIDTH  row-RAM write address.
- ram_w_data  output  DATA_WIDTH  row-RAM write data.
- busy  output  1  high from the first ISSUE cycle through the last write cycle.
- done  output  1  one-cycle completion pulse.
- cmd_err  output  1  one-cycle pulse on an illegal command.

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, all counters 0, and every output 0 (bram_addr, bram_en, ram_w_en, ram_w_addr, busy, done, cmd_err). ram_w_data is a combinational pass-through of bram_rdata.
- Reset mid-transfer aborts immediately. No write occurs in the cycle after reset, even if a read was in flight.
- States: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - start=1 with a legal command: latch all command inputs, clear the row counter r and column counter k, go to ISSUE.
  - A command is illegal if num_rows==0, num_rows>ARRAY_N, row_len==0, row_len>RAM_SIZE, or bram_base_addr[1:0]!=0. An illegal command pulses cmd_err for one cycle, issues no reads, stays in IDLE and does not pulse done.
- ISSUE, each cycle with hold=0:
  - bram_en=1 and bram_addr = base + 4*(r*row_len + k), computed 32-bit with wrap modulo 2^32.
  - Advance k. When k reaches row_len-1, set k=0 and r=r+1.
  - After issuing the final word (r=num_rows-1, k=row_len-1), go to DRAIN.
- ISSUE with hold=1: bram_en=0, counters frozen, bram_addr holds its last value. hold is ignored in IDLE, DRAIN and FIN.
- Write pipeline:
  - One register stage captures the issue valid flag, onehot(r) and ram_base_addr+k (ADDR_WIDTH bits, wraps modulo RAM_SIZE).
  - In the cycle after each issued read: ram_w_en = the registered one-hot, ram_w_addr = the registered address, ram_w_data = bram_rdata.
  - A cycle with no issued read yields ram_w_en=0 the following cycle.
- DRAIN: one cycle in which the final write occurs; then go to FIN.
- FIN: done=1 and busy=0 for one cycle; then go to IDLE. A start during FIN is ignored.
- busy: 1 in ISSUE and DRAIN, 0 otherwise.
- start while busy is ignored, with no error.
- Latency, with start sampled at edge 0 and no hold:
  - bram_en high for cycles 1..T, where T = num_rows*row_len.
  - ram_w_en non-zero for cycles 2..T+1.
  - done at cycle T+2.
  - A new start is accepted at cycle T+3 or later.
- Write order is row-major. Exactly T writes occur, with exactly one ram_w_en bit set per write.

Test Plan:
- Basic load: base=0x100, num_rows=2, row_len=3, ram_base=5, BRAM word at byte address A = A.
  - bram_addr = 0x100,0x104,…,0x114 on cycles 1..6.
  - Writes (ram_w_en, addr, data): (0x01,5,0x100), (0x01,6,0x104), (0x01,7,0x108), (0x02,5,0x10C), (0x02,6,0x110), (0x02,7,0x114) on cycles 2..7.
  - done on cycle 8.
- Stall: same command with hold=1 on cycles 2-3.
  - bram_en low on cycles 2-3.
  - ram_w_en=0 on cycles 3-4.
  - All 6 writes arrive with the same addresses and data; done on cycle 10.
- Full array / wrap: num_rows=8, row_len=4, ram_base=1022.
  - Row RAM addresses written are 1022,1023,0,1 in every row.
  - One-hot enables step 0x01..0x80; exactly 32 writes.
- Illegal commands, each one separately: num_rows=0, num_rows=9, row_len=0, base=0x102.
  - Each gives a cmd_err pulse the next cycle, with bram_en, ram_w_en, busy and done all staying 0.
- Reset mid-transfer: assert reset_n=0 on cycle 4 of the basic load.
  - Next cycle: every output 0 and no further writes.
  - A new start after release completes normally.
- start while busy: pulse start at cycle 3 with different inputs.
  - Ignored: the original transfer completes unchanged and produces a single done pulse.
